// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared addresses, command encoding and cause codes for the M-mode CSR file
package csr_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_RW   = 2'b01,
    CMD_RS   = 2'b10,
    CMD_RC   = 2'b11
  } csr_cmd_e;

  localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] ADDR_MISA          = 12'h301;
  localparam logic [11:0] ADDR_MIE           = 12'h304;
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] ADDR_MIP           = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [4:0] IRQ_MSI       = 5'd3;
  localparam logic [4:0] IRQ_MTI       = 5'd7;
  localparam logic [4:0] IRQ_MEI       = 5'd11;
  localparam logic [4:0] IRQ_FAST_BASE = 5'd16;

  // Read-modify-write result of a CSR instruction against the old value.
  function automatic logic [31:0] csr_apply(csr_cmd_e cmd, logic [31:0] old, logic [31:0] operand);
    case (cmd)
      CMD_RW:  return operand;
      CMD_RS:  return old | operand;
      CMD_RC:  return old & ~operand;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - CNT_WIDTH event counter with 32-bit half loads and inhibit
module csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [63:0]          loaded;

  // Next count: a half load replaces the increment for that cycle; bits above CNT_WIDTH drop.
  always_comb begin
    loaded = 64'(cnt_q);
    if (wr_lo_i) loaded[31:0]  = wdata_i;
    if (wr_hi_i) loaded[63:32] = wdata_i;
    if (wr_lo_i || wr_hi_i) begin
      cnt_d = loaded[CNT_WIDTH-1:0];
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = 64'(cnt_q);

endmodule

// File: rtl/csr_file_irq.sv
// rtl/csr_file_irq.sv - parametrised M-mode CSR file with interrupts, traps and counters
module csr_file_irq
  import csr_pkg::*;
#(
  parameter int          NUM_FAST_IRQ = 4,
  parameter int          CNT_WIDTH    = 64,
  parameter bit          VECTORED_EN  = 1'b1,
  parameter logic [31:0] MTVEC_RESET  = 32'h0,
  parameter logic [31:0] HART_ID      = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_en,
  input  logic [1:0]  csr_cmd,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic [31:0] cinst_pc,
  input  logic        exception_i,
  input  logic [4:0]  e_code,
  input  logic [31:0] exc_tval,
  input  logic        timer_irq,
  input  logic        soft_irq,
  input  logic        external_irq,
  input  logic [(NUM_FAST_IRQ > 0 ? NUM_FAST_IRQ : 1)-1:0] fast_irq,
  input  logic        instr_retired,
  input  logic        trap_ret,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] mepc,
  output logic [31:0] trap_cause
);

  localparam logic [31:0] FAST_MASK = 32'(((64'd1 << NUM_FAST_IRQ) - 64'd1) << 16);
  localparam logic [31:0] MIE_MASK  = FAST_MASK | 32'h0000_0888;

  csr_cmd_e    cmd;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] minhibit_q, minhibit_d;
  logic [63:0] mcycle_val, minstret_val;
  logic [31:0] mstatus_val, mip_val, pend, rd_val, wval, mtvec_base;
  logic        impl, cmd_active, wr_en, irq_take;
  logic [4:0]  irq_code;

  assign cmd         = csr_cmd_e'(csr_cmd);
  assign mstatus_val = MSTATUS_MPP_M | (32'(mstatus_mpie_q) << MSTATUS_MPIE)
                                     | (32'(mstatus_mie_q) << MSTATUS_MIE);
  assign mip_val     = ((32'(fast_irq) << 16) & FAST_MASK)
                     | {20'b0, external_irq, 3'b0, timer_irq, 3'b0, soft_irq, 3'b0};

  // Address decode and pre-update read value; unknown addresses read 0 and flag unimplemented.
  always_comb begin
    rd_val = '0;
    impl   = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:                  rd_val = mstatus_val;
      ADDR_MISA:                     rd_val = MISA_VALUE;
      ADDR_MIE:                      rd_val = mie_q;
      ADDR_MTVEC:                    rd_val = mtvec_q;
      ADDR_MCOUNTINHIBIT:            rd_val = minhibit_q;
      ADDR_MSCRATCH:                 rd_val = mscratch_q;
      ADDR_MEPC:                     rd_val = mepc_q;
      ADDR_MCAUSE:                   rd_val = mcause_q;
      ADDR_MTVAL:                    rd_val = mtval_q;
      ADDR_MIP:                      rd_val = mip_val;
      ADDR_MCYCLE,    ADDR_CYCLE:    rd_val = mcycle_val[31:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   rd_val = mcycle_val[63:32];
      ADDR_MINSTRET,  ADDR_INSTRET:  rd_val = minstret_val[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: rd_val = minstret_val[63:32];
      ADDR_MHARTID:                  rd_val = HART_ID;
      default:                       impl   = 1'b0;
    endcase
  end

  assign cmd_active  = csr_en && (cmd != CMD_NONE);
  assign csr_illegal = cmd_active &&
                       (!impl || ((csr_addr[11:10] == 2'b11) && ((cmd == CMD_RW) || (csr_wdata != 32'h0))));
  assign csr_rdata   = (csr_en && !csr_illegal) ? rd_val : 32'h0;
  assign wval        = csr_apply(cmd, rd_val, csr_wdata);
  assign wr_en       = cmd_active && !csr_illegal && !trap;

  // Interrupt arbitration: later assignments win, so MEI > MSI > MTI > highest fast line.
  always_comb begin
    irq_code = '0;
    for (int i = 0; i < NUM_FAST_IRQ; i++) begin
      if (pend[16+i]) irq_code = IRQ_FAST_BASE + 5'(i);
    end
    if (pend[IRQ_MTI]) irq_code = IRQ_MTI;
    if (pend[IRQ_MSI]) irq_code = IRQ_MSI;
    if (pend[IRQ_MEI]) irq_code = IRQ_MEI;
  end

  assign pend       = mip_val & mie_q;
  assign irq_take   = mstatus_mie_q && (pend != 32'h0);
  assign trap       = !reset && (exception_i || irq_take);
  assign trap_cause = exception_i ? {27'b0, e_code} : {1'b1, 26'b0, irq_code};
  assign mtvec_base = {mtvec_q[31:2], 2'b00};
  assign trap_pc    = (!exception_i && (mtvec_q[1:0] == 2'b01))
                    ? mtvec_base + {25'b0, irq_code, 2'b00} : mtvec_base;
  assign mepc       = mepc_q;

  // Next-state: a trap overrides mret and every CSR write; mret overrides a same-cycle mstatus write.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    minhibit_d     = minhibit_q;
    if (trap) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = {cinst_pc[31:2], 2'b00};
      mcause_d       = trap_cause;
      mtval_d        = exception_i ? exc_tval : 32'h0;
    end else begin
      if (trap_ret) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end else if (wr_en && (csr_addr == ADDR_MSTATUS)) begin
        mstatus_mie_d  = wval[MSTATUS_MIE];
        mstatus_mpie_d = wval[MSTATUS_MPIE];
      end
      if (wr_en) begin
        case (csr_addr)
          ADDR_MIE:           mie_d      = wval & MIE_MASK;
          ADDR_MTVEC:         mtvec_d    = {wval[31:2], (VECTORED_EN && (wval[1:0] == 2'b01)) ? 2'b01 : 2'b00};
          ADDR_MCOUNTINHIBIT: minhibit_d = wval & 32'h0000_0005;
          ADDR_MSCRATCH:      mscratch_d = wval;
          ADDR_MEPC:          mepc_d     = {wval[31:2], 2'b00};
          ADDR_MCAUSE:        mcause_d   = wval;
          ADDR_MTVAL:         mtval_d    = wval;
          default: ;
        endcase
      end
    end
  end

  // CSR state registers; reset wins over any trap or write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      minhibit_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      minhibit_q     <= minhibit_d;
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (1'b1),
    .inhibit_i (minhibit_q[0]),
    .wr_lo_i   (wr_en && (csr_addr == ADDR_MCYCLE)),
    .wr_hi_i   (wr_en && (csr_addr == ADDR_MCYCLEH)),
    .wdata_i   (wval),
    .count_o   (mcycle_val)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (instr_retired),
    .inhibit_i (minhibit_q[2]),
    .wr_lo_i   (wr_en && (csr_addr == ADDR_MINSTRET)),
    .wr_hi_i   (wr_en && (csr_addr == ADDR_MINSTRETH)),
    .wdata_i   (wval),
    .count_o   (minstret_val)
  );

endmodule

// File: tb/tb_csr_file_irq.sv
// tb/tb_csr_file_irq.sv - scoreboard bench for csr_file_irq against an address-map reference model
module tb_csr_file_irq;

  localparam logic [31:0] HART     = 32'h0000_0005;
  localparam logic [31:0] TVEC_RST = 32'h0000_0080;
  localparam logic [1:0]  RW = 2'b01, RS = 2'b10, RC = 2'b11, NONE = 2'b00;

  logic        clk = 1'b0;
  logic        reset, csr_en, csr_illegal, exception_i, timer_irq, soft_irq, external_irq;
  logic        instr_retired, trap_ret, trap;
  logic [1:0]  csr_cmd;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, cinst_pc, exc_tval, trap_pc, mepc, trap_cause;
  logic [4:0]  e_code;
  logic [3:0]  fast_irq;

  always #5 clk = ~clk;

  csr_file_irq #(
    .NUM_FAST_IRQ (4),
    .CNT_WIDTH    (64),
    .VECTORED_EN  (1'b1),
    .MTVEC_RESET  (TVEC_RST),
    .HART_ID      (HART)
  ) dut (
    .clk (clk), .reset (reset), .csr_en (csr_en), .csr_cmd (csr_cmd), .csr_addr (csr_addr),
    .csr_wdata (csr_wdata), .csr_rdata (csr_rdata), .csr_illegal (csr_illegal),
    .cinst_pc (cinst_pc), .exception_i (exception_i), .e_code (e_code), .exc_tval (exc_tval),
    .timer_irq (timer_irq), .soft_irq (soft_irq), .external_irq (external_irq),
    .fast_irq (fast_irq), .instr_retired (instr_retired), .trap_ret (trap_ret),
    .trap (trap), .trap_pc (trap_pc), .mepc (mepc), .trap_cause (trap_cause)
  );

  typedef struct {
    logic rst; logic en; logic [1:0] cmd; logic [11:0] addr; logic [31:0] wdata;
    logic [31:0] pc; logic exc; logic [4:0] ecode; logic [31:0] tval;
    logic tmr; logic sft; logic ext; logic [3:0] fast; logic ret; logic retire;
  } stim_t;

  typedef struct {
    int id; logic chk_csr; logic chk_mepc; logic trap;
    logic [31:0] tpc; logic [31:0] cause; logic illegal; logic [31:0] rdata; logic [31:0] mepc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Reference model: CSR contents by address plus the two 64-bit counters.
  logic [31:0] regs[int];
  logic [63:0] m_cycle, m_instret;
  int          prio[7] = '{11, 3, 7, 19, 18, 17, 16};

  function automatic void model_reset();
    regs['h300] = 32'h1800; regs['h304] = 0; regs['h305] = TVEC_RST; regs['h320] = 0;
    regs['h340] = 0; regs['h341] = 0; regs['h342] = 0; regs['h343] = 0;
    m_cycle = 0; m_instret = 0;
  endfunction

  function automatic bit is_impl(int a);
    return a inside {'h300, 'h301, 'h304, 'h305, 'h320, 'h340, 'h341, 'h342, 'h343, 'h344,
                     'hB00, 'hB80, 'hB02, 'hB82, 'hC00, 'hC80, 'hC02, 'hC82, 'hF14};
  endfunction

  function automatic logic [31:0] legalize(int a, logic [31:0] v);
    logic [1:0] mode;
    mode = v[1:0];
    case (a)
      'h300:   return (v & 32'h88) | 32'h1800;
      'h304:   return v & 32'h000F_0888;
      'h305:   return (v & ~32'h3) | ((mode == 2'b01) ? 32'h1 : 32'h0);
      'h320:   return v & 32'h5;
      'h341:   return v & ~32'h3;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] model_read(int a, logic [31:0] mip);
    case (a)
      'h300, 'h304, 'h305, 'h320, 'h340, 'h341, 'h342, 'h343: return regs[a];
      'h301:         return 32'h4000_0100;
      'h344:         return mip;
      'hB00, 'hC00:  return m_cycle[31:0];
      'hB80, 'hC80:  return m_cycle[63:32];
      'hB02, 'hC02:  return m_instret[31:0];
      'hB82, 'hC82:  return m_instret[63:32];
      'hF14:         return HART;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Drive one cycle, push what the DUT must show during it, then advance the model across the edge.
  task automatic step(input stim_t s);
    exp_t        e;
    logic [31:0] mip, pend, mst, old, nv, base, tvec, inh;
    int          code, a;
    bit          writing, cyc_ld, ins_ld;
    @(posedge clk); #1;
    reset = s.rst; csr_en = s.en; csr_cmd = s.cmd; csr_addr = s.addr; csr_wdata = s.wdata;
    cinst_pc = s.pc; exception_i = s.exc; e_code = s.ecode; exc_tval = s.tval;
    timer_irq = s.tmr; soft_irq = s.sft; external_irq = s.ext; fast_irq = s.fast;
    trap_ret = s.ret; instr_retired = s.retire;

    a    = int'(s.addr);
    mip  = (32'(s.fast) << 16) | (s.ext ? 32'h800 : 0) | (s.tmr ? 32'h80 : 0) | (s.sft ? 32'h8 : 0);
    pend = mip & regs['h304];
    mst  = regs['h300];
    tvec = regs['h305];
    base = tvec & ~32'h3;
    code = -1;
    foreach (prio[k]) if (code < 0 && pend[prio[k]]) code = prio[k];

    e.id       = step_id++;
    e.trap     = !s.rst && (s.exc || (mst[3] && code >= 0));
    e.cause    = s.exc ? 32'(s.ecode) : (32'h8000_0000 | 32'(code));
    e.tpc      = (!s.exc && tvec[1:0] == 2'b01) ? base + 32'(4 * code) : base;
    e.illegal  = s.en && s.cmd != NONE &&
                 (!is_impl(a) || (s.addr[11:10] == 2'b11 && (s.cmd == RW || s.wdata != 0)));
    old        = model_read(a, mip);
    e.rdata    = e.illegal ? 32'h0 : old;
    e.chk_csr  = s.en && !s.rst;
    e.chk_mepc = !s.rst;
    e.mepc     = regs['h341];
    sb.push_back(e);

    if (s.rst) begin
      model_reset();
      return;
    end
    writing = s.en && s.cmd != NONE && !e.illegal && !e.trap;
    nv      = (s.cmd == RW) ? s.wdata : (s.cmd == RS) ? (old | s.wdata) : (old & ~s.wdata);
    inh     = regs['h320];
    cyc_ld  = 0;
    ins_ld  = 0;
    if (e.trap) begin
      regs['h341] = s.pc & ~32'h3;
      regs['h342] = e.cause;
      regs['h343] = s.exc ? s.tval : 32'h0;
      regs['h300] = 32'h1800 | (mst[3] ? 32'h80 : 32'h0);
    end else begin
      if (s.ret) regs['h300] = 32'h1880 | (mst[7] ? 32'h8 : 32'h0);
      if (writing) begin
        case (a)
          'h300: if (!s.ret) regs[a] = legalize(a, nv);
          'h304, 'h305, 'h320, 'h340, 'h341, 'h342, 'h343: regs[a] = legalize(a, nv);
          'hB00: begin m_cycle   = {m_cycle[63:32], nv};   cyc_ld = 1; end
          'hB80: begin m_cycle   = {nv, m_cycle[31:0]};    cyc_ld = 1; end
          'hB02: begin m_instret = {m_instret[63:32], nv}; ins_ld = 1; end
          'hB82: begin m_instret = {nv, m_instret[31:0]};  ins_ld = 1; end
          default: ;
        endcase
      end
    end
    if (!cyc_ld && !inh[0]) m_cycle = m_cycle + 1;
    if (!ins_ld && s.retire && !inh[2]) m_instret = m_instret + 1;
  endtask

  task automatic csr_op(input logic [1:0] cmd, input logic [11:0] addr, input logic [31:0] wd);
    stim_t s;
    s = idle();
    s.en = 1; s.cmd = cmd; s.addr = addr; s.wdata = wd;
    step(s);
  endtask

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Monitor: each cycle's expectation is popped mid-cycle, while the DUT outputs are settled.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("trap", e.id, 32'(trap), 32'(e.trap));
      if (e.trap) begin
        check("trap_pc", e.id, trap_pc, e.tpc);
        check("trap_cause", e.id, trap_cause, e.cause);
      end
      if (e.chk_csr) begin
        check("csr_illegal", e.id, 32'(csr_illegal), 32'(e.illegal));
        check("csr_rdata", e.id, csr_rdata, e.rdata);
      end
      if (e.chk_mepc) check("mepc", e.id, mepc, e.mepc);
    end
  end

  logic [11:0] rnd_addrs[24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h345, 12'h7C0,
                                 12'hC01, 12'h300, 12'h304};
  logic [11:0] rst_addrs[10] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h341,
                                 12'h342, 12'h343, 12'hB00, 12'hF14};

  initial begin
    stim_t s;
    model_reset();
    s = idle(); s.rst = 1;
    step(s); step(s);
    foreach (rst_addrs[i]) csr_op(NONE, rst_addrs[i], 0);

    // Vectored external interrupt.
    csr_op(RW, 12'h305, 32'h101);
    csr_op(RW, 12'h304, 32'h800);
    csr_op(RS, 12'h300, 32'h8);
    s = idle(); s.ext = 1; s.pc = 32'h0000_4004; step(s);
    csr_op(NONE, 12'h300, 0);
    csr_op(NONE, 12'h342, 0);

    // Exception beats a pending timer interrupt, then mret restores MIE.
    csr_op(RW, 12'h304, 32'h80);
    csr_op(RS, 12'h300, 32'h8);
    s = idle(); s.tmr = 1; s.exc = 1; s.ecode = 5'd2; s.tval = 32'hDEAD_BEEF; s.pc = 32'h0000_2000;
    step(s);
    s = idle(); s.ret = 1; step(s);
    csr_op(NONE, 12'h300, 0);
    csr_op(NONE, 12'h343, 0);
    csr_op(RC, 12'h300, 32'h8);

    // mcycle wrap and inhibit.
    csr_op(RW, 12'hB00, 32'hFFFF_FFFF);
    csr_op(RW, 12'hB80, 32'hFFFF_FFFF);
    csr_op(NONE, 12'hB00, 0);
    csr_op(NONE, 12'hB00, 0);
    csr_op(NONE, 12'hB80, 0);
    csr_op(RW, 12'h320, 32'h1);
    repeat (10) csr_op(NONE, 12'hC00, 0);
    csr_op(RW, 12'h320, 32'h0);

    // Read-only space and mhartid.
    csr_op(RW, 12'hC00, 32'h1234);
    csr_op(RS, 12'hF14, 32'h0);
    csr_op(RS, 12'hF14, 32'h1);

    // Fast interrupt drops a same-cycle CSR write.
    csr_op(RW, 12'h304, 32'h000F_0000);
    csr_op(RW, 12'h340, 32'h55);
    csr_op(RS, 12'h300, 32'h8);
    s = idle(); s.fast = 4'b0101; s.en = 1; s.cmd = RW; s.addr = 12'h340; s.wdata = 32'hAA; s.pc = 32'h300;
    step(s);
    csr_op(NONE, 12'h340, 0);

    // WARL mtvec mode and read-only mip.
    csr_op(RW, 12'h305, 32'h203);
    csr_op(NONE, 12'h305, 0);
    s = idle(); s.sft = 1; s.tmr = 1; s.en = 1; s.cmd = RW; s.addr = 12'h344; s.wdata = 32'hFFFF; step(s);
    s = idle(); s.ext = 1; s.fast = 4'b1010; s.en = 1; s.addr = 12'h344; step(s);

    // Reset during a trap leaves no trace of it.
    s = idle(); s.rst = 1; s.exc = 1; s.ecode = 5'd5; s.pc = 32'h8888; step(s);
    csr_op(NONE, 12'h342, 0);
    csr_op(NONE, 12'h341, 0);

    // Randomised traffic.
    for (int n = 0; n < 500; n++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 149) == 0);
      s.en     = ($urandom_range(0, 3) != 0);
      s.cmd    = 2'($urandom_range(0, 3));
      s.addr   = rnd_addrs[$urandom_range(0, 23)];
      s.wdata  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      s.pc     = $urandom();
      s.exc    = ($urandom_range(0, 11) == 0);
      s.ecode  = 5'($urandom_range(0, 31));
      s.tval   = $urandom();
      s.tmr    = ($urandom_range(0, 3) == 0);
      s.sft    = ($urandom_range(0, 3) == 0);
      s.ext    = ($urandom_range(0, 5) == 0);
      s.fast   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      s.ret    = ($urandom_range(0, 9) == 0);
      s.retire = 1'($urandom_range(0, 1));
      step(s);
    end

    s = idle();
    step(s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("scoreboard_drained", step_id, 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
